uart_tx_frame: RTL and testbench

Parametrised UART transmit engine for the UART TX path: frame FSM, serializer, parity generator and a one-entry holding buffer in a single block. Transmits frames of DATA_WIDTH bits at one bit per CLK cycle; CLK is the TX bit clock from the clock divider. The parity enable, parity type and stop-bit count are runtime inputs, latched per frame. The holding buffer accepts a second word while a frame is in flight, so frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_shift.sv | 57 +++++
 rtl/uart_tx_frame.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } tx_state_e;

    localparam logic PAR_EVEN      = 1'b0;
    localparam logic PAR_ODD       = 1'b1;
    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_shift.sv
// Data serializer: rotating shift register, bit counter, last-bit flag and parity.
// The register rotates rather than shifts, so after a full frame it holds the
// original word again and parity stays valid for the whole frame.
module uart_tx_shift
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  cnt_en,
    output logic                  tx_bit,
    output logic                  last_bit,
    output logic                  parity
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign tx_bit   = sr_q[0];
    assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign parity   = ^sr_q;

    // Next-state for the shift register and bit counter; counter wraps after the last bit.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else begin
            if (shift_en) begin
                sr_d = {sr_q[0], sr_q[DATA_WIDTH-1:1]};
            end
            if (cnt_en) begin
                cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: frame FSM, one-entry holding buffer and registered line driver.
// TX_OUT, busy and frame_done are registered and computed from the next state, so the
// value on the line always matches the state the FSM has just entered.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  ready,
    output logic                  frame_done
);

    tx_state_e state_q, state_d;

    logic tx_q, tx_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Config of the frame currently on the line.
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic stop2_q, stop2_d;

    // Holding buffer.
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_par_en_q, buf_par_en_d;
    logic                  buf_par_typ_q, buf_par_typ_d;
    logic                  buf_stop2_q, buf_stop2_d;

    logic                  sh_load;
    logic [DATA_WIDTH-1:0] sh_load_data;
    logic                  sh_shift_en;
    logic                  sh_cnt_en;
    logic                  sh_tx_bit;
    logic                  sh_last_bit;
    logic                  sh_parity;

    logic accept;
    logic frame_end;

    assign ready      = !buf_full_q;
    assign accept     = Data_Valid && !buf_full_q;
    assign TX_OUT     = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    uart_tx_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift_en  (sh_shift_en),
        .cnt_en    (sh_cnt_en),
        .tx_bit    (sh_tx_bit),
        .last_bit  (sh_last_bit),
        .parity    (sh_parity)
    );

    // Frame sequencing, word acceptance and holding-buffer management.
    always_comb begin
        state_d       = state_q;
        frame_end     = 1'b0;
        sh_load       = 1'b0;
        sh_load_data  = P_DATA;
        sh_shift_en   = 1'b0;
        sh_cnt_en     = 1'b0;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        stop2_d       = stop2_q;
        buf_full_d    = buf_full_q;
        buf_data_d    = buf_data_q;
        buf_par_en_d  = buf_par_en_q;
        buf_par_typ_d = buf_par_typ_q;
        buf_stop2_d   = buf_stop2_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_load   = 1'b1;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                    state_d   = StStart;
                end
            end
            StStart: begin
                // First rotation exposes bit 1 while bit 0 is registered onto the line.
                state_d     = StData;
                sh_shift_en = 1'b1;
            end
            StData: begin
                sh_cnt_en = 1'b1;
                if (sh_last_bit) begin
                    state_d = par_en_q ? StParity : StStop1;
                end else begin
                    sh_shift_en = 1'b1;
                end
            end
            StParity: begin
                state_d = StStop1;
            end
            StStop1: begin
                if (stop2_q) begin
                    state_d = StStop2;
                end else begin
                    frame_end = 1'b1;
                end
            end
            StStop2: begin
                frame_end = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (frame_end) begin
            if (buf_full_q) begin
                sh_load      = 1'b1;
                sh_load_data = buf_data_q;
                par_en_d     = buf_par_en_q;
                par_typ_d    = buf_par_typ_q;
                stop2_d      = buf_stop2_q;
                buf_full_d   = 1'b0;
                state_d      = StStart;
            end else if (accept) begin
                // Bypass the buffer so the next start bit follows with no gap.
                sh_load   = 1'b1;
                par_en_d  = PAR_EN;
                par_typ_d = PAR_TYP;
                stop2_d   = STOP2;
                state_d   = StStart;
            end else begin
                state_d = StIdle;
            end
        end else if (accept && (state_q != StIdle)) begin
            buf_full_d    = 1'b1;
            buf_data_d    = P_DATA;
            buf_par_en_d  = PAR_EN;
            buf_par_typ_d = PAR_TYP;
            buf_stop2_d   = STOP2;
        end
    end

    // Line level, busy and frame_done for the state being entered.
    always_comb begin
        tx_d   = TX_IDLE_LEVEL;
        busy_d = (state_d != StIdle);
        done_d = (state_d == StStop2) || ((state_d == StStop1) && !stop2_q);
        unique case (state_d)
            StIdle:           tx_d = TX_IDLE_LEVEL;
            StStart:          tx_d = ~TX_IDLE_LEVEL;
            StData:           tx_d = sh_tx_bit;
            StParity:         tx_d = (par_typ_q == PAR_ODD) ? ~sh_parity : sh_parity;
            StStop1, StStop2: tx_d = TX_IDLE_LEVEL;
            default:          tx_d = TX_IDLE_LEVEL;
        endcase
    end

    // State, output and buffer registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            tx_q          <= TX_IDLE_LEVEL;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            stop2_q       <= 1'b0;
            buf_full_q    <= 1'b0;
            buf_data_q    <= '0;
            buf_par_en_q  <= 1'b0;
            buf_par_typ_q <= PAR_EVEN;
            buf_stop2_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            stop2_q       <= stop2_d;
            buf_full_q    <= buf_full_d;
            buf_data_q    <= buf_data_d;
            buf_par_en_q  <= buf_par_en_d;
            buf_par_typ_q <= buf_par_typ_d;
            buf_stop2_q   <= buf_stop2_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames, back-to-back, mid-frame reset, a 5-bit
// instance, and random traffic checked against a queue-based line model.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] P_DATA;
    logic       Data_Valid, PAR_EN, PAR_TYP, STOP2;
    logic       TX_OUT, busy, ready, frame_done;

    logic [4:0] p_data5;
    logic       dv5, pe5, pt5, s25;
    logic       tx5, busy5, ready5, fd5;

    int checks = 0;
    int errors = 0;

    // Line model: each entry is {last_stop_bit, line_level} for one cycle.
    logic [1:0] m_q[$];
    bit         m_held;
    logic [7:0] m_hd;
    bit         m_hpe, m_hpt, m_hs2;

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .ready      (ready),
        .frame_done (frame_done)
    );

    uart_tx_frame #(.DATA_WIDTH(5)) dut5 (
        .CLK        (CLK),
        .RESET      (RESET),
        .P_DATA     (p_data5),
        .Data_Valid (dv5),
        .PAR_EN     (pe5),
        .PAR_TYP    (pt5),
        .STOP2      (s25),
        .TX_OUT     (tx5),
        .busy       (busy5),
        .ready      (ready5),
        .frame_done (fd5)
    );

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Append the cycles of one 8-bit frame to the line model.
    task automatic push_frame(input logic [7:0] d, input bit pe, input bit pt, input bit s2);
        int ones = 0;
        m_q.push_back(2'b00);
        for (int i = 0; i < 8; i++) begin
            m_q.push_back({1'b0, d[i]});
            ones += int'(d[i]);
        end
        if (pe) m_q.push_back({1'b0, 1'(ones % 2) ^ pt});
        if (s2) m_q.push_back(2'b01);
        m_q.push_back(2'b11);
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input bit present, input logic [7:0] d, input bit p_en,
                        input bit p_typ, input bit s_2, output bit acc, output logic tx_seen);
        logic exp_tx, exp_busy, exp_fd;
        exp_busy = (m_q.size() != 0);
        exp_tx   = exp_busy ? m_q[0][0] : 1'b1;
        exp_fd   = exp_busy ? m_q[0][1] : 1'b0;
        chk1("tx_out", TX_OUT, exp_tx);
        chk1("busy", busy, exp_busy);
        chk1("frame_done", frame_done, exp_fd);
        chk1("ready", ready, !m_held);
        tx_seen    = TX_OUT;
        Data_Valid = present;
        P_DATA     = d;
        PAR_EN     = p_en;
        PAR_TYP    = p_typ;
        STOP2      = s_2;
        acc        = present && !m_held;
        if (m_q.size() != 0) void'(m_q.pop_front());
        if (m_q.size() == 0 && m_held) begin
            push_frame(m_hd, m_hpe, m_hpt, m_hs2);
            m_held = 1'b0;
        end
        if (acc) begin
            if (m_q.size() == 0) begin
                push_frame(d, p_en, p_typ, s_2);
            end else begin
                m_held = 1'b1;
                m_hd   = d;
                m_hpe  = p_en;
                m_hpt  = p_typ;
                m_hs2  = s_2;
            end
        end
        @(negedge CLK);
    endtask

    // Send one word from idle and collect the next 11 line cycles, first cycle in the MSB.
    task automatic send_collect(input logic [7:0] d, input bit pe, input bit pt, input bit s2,
                                output logic [10:0] got);
        bit   a;
        logic t;
        got = '0;
        step(1'b1, d, pe, pt, s2, a, t);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, d, pe, pt, s2, a, t);
            got = {got[9:0], t};
        end
    endtask

    initial begin
        bit         a, have, got2, prev_busy;
        logic       t;
        logic [10:0] got;
        logic [7:0]  got5, rd;
        bit          rpe, rpt, rs2;
        int          busy_cnt, rises, fd_cnt;

        RESET = 1'b1; Data_Valid = 1'b0; P_DATA = '0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        dv5 = 1'b0; p_data5 = '0; pe5 = 1'b0; pt5 = 1'b0; s25 = 1'b0;
        m_held = 1'b0;

        @(negedge CLK);
        chk1("reset_tx", TX_OUT, 1'b1);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ready", ready, 1'b1);
        chk1("reset_frame_done", frame_done, 1'b0);
        chk1("reset_tx_w5", tx5, 1'b1);
        RESET = 1'b0;
        @(negedge CLK);

        // 5-bit instance.
        p_data5 = 5'h15; pe5 = 1'b1; pt5 = 1'b0; s25 = 1'b0; dv5 = 1'b1;
        @(negedge CLK);
        dv5 = 1'b0;
        got5 = '0;
        for (int i = 0; i < 8; i++) begin
            got5 = {got5[6:0], tx5};
            @(negedge CLK);
        end
        chkw("frame_w5", 32'(got5), 32'(8'b01010111));
        chk1("idle_tx_w5", tx5, 1'b1);
        chk1("idle_busy_w5", busy5, 1'b0);
        chk1("idle_ready_w5", ready5, 1'b1);

        // Directed frames.
        send_collect(8'hA5, 1'b1, 1'b0, 1'b0, got);
        chkw("frame_a5", 32'(got), 32'(11'b01010010101));
        send_collect(8'h07, 1'b1, 1'b1, 1'b0, got);
        chk1("parity_07_odd", got[1], 1'b0);
        send_collect(8'h07, 1'b1, 1'b0, 1'b0, got);
        chk1("parity_07_even", got[1], 1'b1);
        send_collect(8'h00, 1'b0, 1'b0, 1'b1, got);
        chkw("frame_00_stop2", 32'(got), 32'(11'b00000000011));
        chk1("idle_tx_after", TX_OUT, 1'b1);
        chk1("idle_busy_after", busy, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a, t);

        // Back-to-back: second word offered during the first frame's data bits.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, a, t);
        busy_cnt = 0; rises = 0; fd_cnt = 0; prev_busy = 1'b0; got2 = 1'b0;
        for (int j = 0; j < 29; j++) begin
            if (busy) busy_cnt++;
            if (busy && !prev_busy) rises++;
            if (frame_done) fd_cnt++;
            prev_busy = busy;
            step(j >= 3 && !got2, 8'h0F, 1'b1, 1'b0, 1'b0, a, t);
            if (a) got2 = 1'b1;
        end
        chkw("b2b_busy_cycles", 32'(busy_cnt), 32'd22);
        chkw("b2b_busy_rises", 32'(rises), 32'd1);
        chkw("b2b_frame_done", 32'(fd_cnt), 32'd2);

        // Random traffic; config inputs wander while no word is offered.
        have = 1'b0; rd = '0; rpe = 1'b0; rpt = 1'b0; rs2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!have && ($urandom_range(3) != 0)) begin
                have = 1'b1;
                rd   = 8'($urandom);
                rpe  = 1'($urandom);
                rpt  = 1'($urandom);
                rs2  = 1'($urandom);
            end
            if (have) begin
                step(1'b1, rd, rpe, rpt, rs2, a, t);
                if (a) have = 1'b0;
            end else begin
                step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a, t);
            end
        end
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a, t);

        // Reset on the 3rd data bit of 0xFF with a word in the buffer.
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, a, t);
        step(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, a, t);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a, t);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a, t);
        chk1("pre_reset_ready", ready, 1'b0);
        #1 RESET = 1'b1;
        #1;
        chk1("midreset_tx", TX_OUT, 1'b1);
        chk1("midreset_busy", busy, 1'b0);
        chk1("midreset_ready", ready, 1'b1);
        chk1("midreset_frame_done", frame_done, 1'b0);
        @(posedge CLK);
        #2 RESET = 1'b0;
        @(negedge CLK);
        m_q.delete();
        m_held = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a, t);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
